spi_slave_responder: RTL and testbench

SPI responder (slave) that sits at the far end of the Qsys SPI master link (MOSI/SCLK/SS_n/MISO) and bridges it to on-chip streaming logic. It runs in Mode 0 (CPOL=0, CPHA=0), MSB first. Each received word is presented on a valid-pulse output, and each transmit word is pulled through a ready/valid handshake. All SPI inputs are oversampled in the system clock domain; there is no SCLK clock domain.

---
 rtl/spi_slave_responder_pkg.sv | 25 ++
 rtl/spi_slave_responder_sync_edge.sv | 32 +++
 rtl/spi_slave_responder.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared types and helpers for the SPI responder: FSM state encoding and
// the bit-counter width function.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      ACTIVE    = 2'd2
   } state_t;

   // clk_clk must run at least this many times faster than SCLK
   localparam int MIN_OVERSAMPLE = 8;

   function automatic int clog2(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/spi_slave_responder_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with rise/fall
// detection taken from the synchronized level.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign level = chain[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_responder.sv
// Mode 0, MSB-first SPI responder oversampled in the system clock domain,
// bridging the SPI link to rx valid-pulse and tx ready/valid streams.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_IDLE | after reset; waits for SS_n high so a frame in flight is dropped
// IDLE      | deselected; SS_n falling edge starts a frame and loads tx word
// ACTIVE    | selected; shifting on SCLK edges, SS_n high ends the frame
module spi_slave_responder
   import spi_slave_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '1
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  spi_sclk,
   input  logic                  spi_mosi,
   input  logic                  spi_ss_n,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int            CW       = clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic mosi_q, mosi_rise_unused, mosi_fall_unused;
   logic ss_q, ss_rise_unused, ss_fall;

   state_t                state, state_nxt;
   logic [CW-1:0]         bitcnt;
   logic [DATA_WIDTH-1:0] rx_shreg;
   logic [DATA_WIDTH-1:0] tx_shreg;
   logic                  word_done;

   logic load, shift_in, shift_out, frame_end, abort;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (spi_sclk),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (spi_mosi),
      .level (mosi_q),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   // SS_n resets to "selected" so a frame already running at release is ignored
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (spi_ss_n),
      .level (ss_q),
      .rise  (ss_rise_unused),
      .fall  (ss_fall)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift_in  = 1'b0;
      shift_out = 1'b0;
      frame_end = 1'b0;
      abort     = 1'b0;
      case (state)
         WAIT_IDLE: begin
            if (ss_q) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (ss_fall) begin
               state_nxt = ACTIVE;
               load      = 1'b1;
            end
         end
         ACTIVE: begin
            // deselect wins over any SCLK edge seen in the same cycle
            if (ss_q) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
               abort     = (bitcnt != '0);
            end else if (sclk_rise) begin
               shift_in = 1'b1;
            end else if (sclk_fall) begin
               if (word_done) begin
                  load = 1'b1;
               end else begin
                  shift_out = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = WAIT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state     <= WAIT_IDLE;
         bitcnt    <= '0;
         rx_shreg  <= '0;
         tx_shreg  <= '0;
         word_done <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         rx_valid  <= 1'b0;
         frame_err <= abort;

         if (load) begin
            tx_shreg  <= tx_valid ? tx_data : FILL_WORD;
            bitcnt    <= '0;
            word_done <= 1'b0;
         end else if (shift_out) begin
            tx_shreg <= tx_shreg << 1;
         end

         if (shift_in) begin
            rx_shreg <= {rx_shreg[DATA_WIDTH-2:0], mosi_q};
            if (bitcnt == LAST_BIT) begin
               bitcnt    <= '0;
               word_done <= 1'b1;
               rx_data   <= {rx_shreg[DATA_WIDTH-2:0], mosi_q};
               rx_valid  <= 1'b1;
            end else begin
               bitcnt <= bitcnt + CW'(1);
            end
         end

         // partial words are dropped; a pending reload is cancelled
         if (frame_end) begin
            bitcnt    <= '0;
            word_done <= 1'b0;
         end
      end
   end

   assign busy        = (state == ACTIVE);
   assign spi_miso_oe = busy;
   assign spi_miso    = busy & tx_shreg[DATA_WIDTH-1];
   assign tx_ready    = load;
   assign tx_underrun = load & ~tx_valid;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: a bit-banged Mode 0 master,
// a tx queue driver and a frame-level expectation model.
module tb_spi_slave_responder;

   localparam int DW = 8;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n = 1'b0;
   logic          spi_sclk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_ss_n = 1'b1;
   logic          spi_miso;
   logic          spi_miso_oe;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic [DW-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          tx_underrun;
   logic          frame_err;
   logic          busy;

   always #5 clk_clk = ~clk_clk;

   spi_slave_responder #(
      .DATA_WIDTH  (DW),
      .SYNC_STAGES (2),
      .FILL_WORD   (8'hFF)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .spi_sclk      (spi_sclk),
      .spi_mosi      (spi_mosi),
      .spi_ss_n      (spi_ss_n),
      .spi_miso      (spi_miso),
      .spi_miso_oe   (spi_miso_oe),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_underrun   (tx_underrun),
      .frame_err     (frame_err),
      .busy          (busy)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] tx_q[$];
   logic [DW-1:0] rx_got[$];
   logic [DW-1:0] wq[$];
   int            n_ready = 0;
   int            n_under = 0;
   int            n_ferr  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void update_tx();
      if (tx_q.size() > 0) begin
         tx_valid = 1'b1;
         tx_data  = tx_q[0];
      end else begin
         tx_valid = 1'b0;
         tx_data  = '0;
      end
   endfunction

   function automatic void clear_counts();
      n_ready = 0;
      n_under = 0;
      n_ferr  = 0;
      rx_got.delete();
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   // stream side: observe pulses mid-cycle, consume the tx word at the next edge
   initial begin
      bit pop;
      forever begin
         @(negedge clk_clk);
         pop = 1'b0;
         if (tx_ready) begin
            n_ready++;
            if (tx_valid) pop = 1'b1;
         end
         if (tx_underrun) n_under++;
         if (frame_err)   n_ferr++;
         if (rx_valid)    rx_got.push_back(rx_data);
         if (pop) begin
            @(posedge clk_clk);
            #1;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            update_tx();
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Mode 0 master: MOSI set while SCLK low, MISO sampled just before the rise.
   // With end_frame set the final SCLK fall coincides with SS_n rising.
   task automatic xfer_word(input logic [DW-1:0] mo, input int nbits, input bit end_frame,
                            output logic [DW-1:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[DW-1-i];
         tick(4);
         mi[DW-1-i] = spi_miso;
         spi_sclk = 1'b1;
         tick(4);
         spi_sclk = 1'b0;
         if (end_frame && (i == nbits - 1)) spi_ss_n = 1'b1;
      end
      if (!end_frame) tick(0);
   endtask

   task automatic run_frame(input logic [DW-1:0] words[$]);
      logic [DW-1:0] exp_tx[$];
      logic [DW-1:0] mi;
      int            k, nw;
      exp_tx = tx_q;
      k  = exp_tx.size();
      nw = words.size();
      clear_counts();
      spi_ss_n = 1'b0;
      tick(6);
      chk("busy_sel", busy, 1);
      chk("oe_sel", spi_miso_oe, 1);
      for (int w = 0; w < nw; w++) begin
         xfer_word(words[w], DW, (w == nw - 1), mi);
         chk("miso_word", mi, (w < k) ? exp_tx[w] : 8'hFF);
      end
      tick(8);
      chk("tx_ready_cnt", n_ready, nw);
      chk("underrun_cnt", n_under, (nw > k) ? nw - k : 0);
      chk("frame_err_cnt", n_ferr, 0);
      chk("rx_cnt", rx_got.size(), nw);
      for (int w = 0; w < nw; w++) begin
         if (w < rx_got.size()) chk("rx_word", rx_got[w], words[w]);
      end
      chk("busy_end", busy, 0);
      chk("oe_end", spi_miso_oe, 0);
      chk("miso_idle", spi_miso, 0);
      tx_q.delete();
      update_tx();
   endtask

   initial begin
      logic [DW-1:0] mi;
      int            k, nw;

      tick(4);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_miso", spi_miso, 0);
      chk("rst_oe", spi_miso_oe, 0);
      chk("rst_tx_ready", tx_ready, 0);
      reset_reset_n = 1'b1;
      tick(8);

      // basic exchange
      tx_q.push_back(8'h3C); update_tx();
      wq.delete(); wq.push_back(8'hA5);
      run_frame(wq);
      chk("rx_data_hold", rx_data, 8'hA5);
      tick(4);

      // back-to-back words under one select
      tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); update_tx();
      wq.delete(); wq.push_back(8'h01); wq.push_back(8'h80); wq.push_back(8'hFF);
      run_frame(wq);
      tick(4);

      // underrun
      wq.delete(); wq.push_back(8'h5A);
      run_frame(wq);
      tick(4);

      // abort after 5 rising edges
      tx_q.push_back(8'h77); update_tx();
      clear_counts();
      spi_ss_n = 1'b0;
      tick(6);
      xfer_word(8'hC3, 5, 1'b1, mi);
      tick(8);
      chk("abort_ferr", n_ferr, 1);
      chk("abort_rx_cnt", rx_got.size(), 0);
      chk("abort_busy", busy, 0);
      chk("abort_oe", spi_miso_oe, 0);
      chk("abort_miso", mi[7:3], 5'b01110);
      tx_q.delete(); update_tx();
      tx_q.push_back(8'h5E); update_tx();
      wq.delete(); wq.push_back(8'hC3);
      run_frame(wq);
      tick(4);

      // reset mid-frame, SS_n held low
      tx_q.push_back(8'hAB); update_tx();
      spi_ss_n = 1'b0;
      tick(6);
      xfer_word(8'h3C, 3, 1'b0, mi);
      reset_reset_n = 1'b0;
      tick(2);
      chk("mid_rst_rx_data", rx_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_oe", spi_miso_oe, 0);
      chk("mid_rst_miso", spi_miso, 0);
      chk("mid_rst_ready", tx_ready, 0);
      reset_reset_n = 1'b1;
      tx_q.delete(); update_tx();
      clear_counts();
      xfer_word(8'hE7, 5, 1'b0, mi);
      tick(8);
      chk("post_rst_rx_cnt", rx_got.size(), 0);
      chk("post_rst_ready", n_ready, 0);
      chk("post_rst_busy", busy, 0);
      spi_ss_n = 1'b1;
      tick(8);
      tx_q.push_back(8'h6D); update_tx();
      wq.delete(); wq.push_back(8'h96);
      run_frame(wq);
      tick(4);

      // SS_n rise coincident with the 8th SCLK rise
      tx_q.push_back(8'h42); update_tx();
      clear_counts();
      spi_ss_n = 1'b0;
      tick(6);
      xfer_word(8'h99, 7, 1'b0, mi);
      spi_mosi = 1'b1;
      tick(4);
      spi_sclk = 1'b1;
      spi_ss_n = 1'b1;
      tick(8);
      spi_sclk = 1'b0;
      tick(6);
      chk("simul_ferr", n_ferr, 1);
      chk("simul_rx_cnt", rx_got.size(), 0);
      chk("simul_busy", busy, 0);
      tx_q.delete(); update_tx();
      tick(4);

      // randomized frames
      for (int it = 0; it < 20; it++) begin
         k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) tx_q.push_back(8'($urandom));
         update_tx();
         nw = $urandom_range(1, 3);
         wq.delete();
         for (int j = 0; j < nw; j++) wq.push_back(8'($urandom));
         run_frame(wq);
         tick($urandom_range(2, 6));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
